// File: rtl/frame_draw_sequencer.sv
// Per-frame draw scheduler: clears the back buffer, drains queued rectangle fills into
// sdram_interface, then requests a buffer swap. Optional macro DROP_EMPTY_RECT_EN.
module frame_draw_sequencer #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned X_W         = 10,
  parameter int unsigned Y_W         = 9,
  parameter logic [31:0] BUF0_BASE   = 32'h0000_0000,
  parameter logic [31:0] BUF1_BASE   = 32'h0012_C000,
  parameter logic [31:0] CLEAR_COLOR = 32'h0000_0000
) (
  input  logic           sys_clk,
  input  logic           sys_reset,
  input  logic           frame_go,
  input  logic           frame_commit,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [X_W-1:0] cmd_x_start,
  input  logic [X_W-1:0] cmd_x_length,
  input  logic [Y_W-1:0] cmd_y_start,
  input  logic [Y_W-1:0] cmd_y_length,
  input  logic [31:0]    cmd_color,
  output logic           if_start,
  output logic           if_clear,
  output logic [X_W-1:0] if_x_start,
  output logic [X_W-1:0] if_x_length,
  output logic [Y_W-1:0] if_y_start,
  output logic [Y_W-1:0] if_y_length,
  output logic [31:0]    if_new_color,
  output logic [31:0]    if_base_addr_offset,
  input  logic           if_done,
  output logic           swap_buffer,
  input  logic           swap_done,
  output logic           back_buf,
  output logic           frame_busy
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = 2 * X_W + 2 * Y_W + 32;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, CLEAR_ISSUE, CLEAR_WAIT, DRAW_IDLE, DRAW_ISSUE, DRAW_WAIT, SWAP_ISSUE, SWAP_WAIT
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q;
  logic           commit_pending_q;
  logic           back_buf_q;
  logic           clear_q;
  logic [X_W-1:0] x_start_q, x_length_q;
  logic [Y_W-1:0] y_start_q, y_length_q;
  logic [31:0]    color_q;

  logic           fifo_empty, fifo_full, push, pop;
  logic           load_clear, load_draw, swap_exit, drop_head;
  logic [X_W-1:0] head_x_start, head_x_length;
  logic [Y_W-1:0] head_y_start, head_y_length;
  logic [31:0]    head_color;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  // A pop in this cycle frees a slot, so a full FIFO can still accept a push.
  assign cmd_ready  = !fifo_full || pop;
  assign push       = cmd_valid && cmd_ready;

  assign {head_x_start, head_x_length, head_y_start, head_y_length, head_color} =
      fifo_mem_q[rd_ptr_q];

`ifdef DROP_EMPTY_RECT_EN
  assign drop_head = (head_x_length == '0) || (head_y_length == '0);
`else
  assign drop_head = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    load_clear = 1'b0;
    load_draw  = 1'b0;
    swap_exit  = 1'b0;
    case (state_q)
      IDLE: if (frame_go) begin
        state_d    = CLEAR_ISSUE;
        load_clear = 1'b1;
      end
      CLEAR_ISSUE: state_d = CLEAR_WAIT;
      CLEAR_WAIT:  if (if_done) state_d = DRAW_IDLE;
      DRAW_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (!drop_head) begin
            state_d   = DRAW_ISSUE;
            load_draw = 1'b1;
          end
        end else if (commit_pending_q) begin
          state_d = SWAP_ISSUE;
        end
      end
      DRAW_ISSUE: state_d = DRAW_WAIT;
      DRAW_WAIT:  if (if_done) state_d = DRAW_IDLE;
      SWAP_ISSUE: state_d = SWAP_WAIT;
      SWAP_WAIT: if (swap_done) begin
        state_d   = IDLE;
        swap_exit = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage needs no reset: pointers and count define the contents.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {cmd_x_start, cmd_x_length, cmd_y_start, cmd_y_length, cmd_color};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q          <= IDLE;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      commit_pending_q <= 1'b0;
      back_buf_q       <= 1'b1;
      clear_q          <= 1'b0;
      x_start_q        <= '0;
      x_length_q       <= '0;
      y_start_q        <= '0;
      y_length_q       <= '0;
      color_q          <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (swap_exit) begin
        commit_pending_q <= 1'b0;
        back_buf_q       <= !back_buf_q;
      end else if (frame_commit && (state_q != IDLE)) begin
        commit_pending_q <= 1'b1;
      end
      if (load_clear) begin
        clear_q    <= 1'b1;
        x_start_q  <= '0;
        x_length_q <= X_W'(1);
        y_start_q  <= '0;
        y_length_q <= Y_W'(1);
        color_q    <= CLEAR_COLOR;
      end else if (load_draw) begin
        clear_q    <= 1'b0;
        x_start_q  <= head_x_start;
        x_length_q <= head_x_length;
        y_start_q  <= head_y_start;
        y_length_q <= head_y_length;
        color_q    <= head_color;
      end
    end
  end

  assign if_start            = (state_q == CLEAR_ISSUE) || (state_q == DRAW_ISSUE);
  assign swap_buffer         = (state_q == SWAP_ISSUE);
  assign frame_busy          = (state_q != IDLE);
  assign back_buf            = back_buf_q;
  assign if_base_addr_offset = back_buf_q ? BUF1_BASE : BUF0_BASE;
  assign if_clear            = clear_q;
  assign if_x_start          = x_start_q;
  assign if_x_length         = x_length_q;
  assign if_y_start          = y_start_q;
  assign if_y_length         = y_length_q;
  assign if_new_color        = color_q;

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Directed bench for frame_draw_sequencer with auto-responding sdram_interface and
// pixel buffer controller models; honours DROP_EMPTY_RECT_EN.
module tb_frame_draw_sequencer;

  logic        sys_clk = 1'b0;
  logic        sys_reset = 1'b1;
  logic        frame_go = 1'b0, frame_commit = 1'b0, cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_x_start = '0, cmd_x_length = '0;
  logic [8:0]  cmd_y_start = '0, cmd_y_length = '0;
  logic [31:0] cmd_color = '0;
  logic        if_start, if_clear;
  logic [9:0]  if_x_start, if_x_length;
  logic [8:0]  if_y_start, if_y_length;
  logic [31:0] if_new_color, if_base_addr_offset;
  logic        if_done = 1'b0;
  logic        swap_buffer;
  logic        swap_done = 1'b0;
  logic        back_buf, frame_busy;

  frame_draw_sequencer dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .frame_go(frame_go), .frame_commit(frame_commit),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x_start(cmd_x_start), .cmd_x_length(cmd_x_length),
    .cmd_y_start(cmd_y_start), .cmd_y_length(cmd_y_length), .cmd_color(cmd_color),
    .if_start(if_start), .if_clear(if_clear),
    .if_x_start(if_x_start), .if_x_length(if_x_length),
    .if_y_start(if_y_start), .if_y_length(if_y_length),
    .if_new_color(if_new_color), .if_base_addr_offset(if_base_addr_offset),
    .if_done(if_done), .swap_buffer(swap_buffer), .swap_done(swap_done),
    .back_buf(back_buf), .frame_busy(frame_busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic        clr;
    logic [9:0]  xs, xl;
    logic [8:0]  ys, yl;
    logic [31:0] col;
    logic [31:0] off;
  } rec_t;

  rec_t recs[$];
  rec_t last_rec;
  logic have_last = 1'b0;
  int   stab_err = 0;
  int   n_swap = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   done_cnt = 0;
  logic done_pend = 1'b0;
  logic hold_done = 1'b0;
  int   swap_cnt = 0;

  function automatic rec_t mk(logic clr, logic [9:0] xs, logic [9:0] xl, logic [8:0] ys,
                              logic [8:0] yl, logic [31:0] col, logic [31:0] off);
    rec_t r;
    r = '{clr: clr, xs: xs, xl: xl, ys: ys, yl: yl, col: col, off: off};
    return r;
  endfunction

  // Issue log plus argument-stability watch between start pulses.
  always @(negedge sys_clk) begin
    rec_t cur;
    cur = mk(if_clear, if_x_start, if_x_length, if_y_start, if_y_length, if_new_color,
             if_base_addr_offset);
    if (sys_reset) begin
      have_last = 1'b0;
    end else begin
      if (if_start) begin
        recs.push_back(cur);
        last_rec  = cur;
        have_last = 1'b1;
      end else if (have_last && (cur.clr != last_rec.clr || cur.xs != last_rec.xs ||
                 cur.xl != last_rec.xl || cur.ys != last_rec.ys || cur.yl != last_rec.yl ||
                 cur.col != last_rec.col)) begin
        stab_err++;
      end
      if (swap_buffer) n_swap++;
    end
  end

  // sdram_interface model: done three cycles after start, can be held off.
  always @(negedge sys_clk) begin
    if_done = 1'b0;
    if (if_start) done_cnt = 3;
    else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) done_pend = 1'b1;
    end
    if (done_pend && !hold_done) begin
      if_done   = 1'b1;
      done_pend = 1'b0;
    end
  end

  // pixel buffer controller model: ack two cycles after swap request.
  always @(negedge sys_clk) begin
    swap_done = 1'b0;
    if (swap_buffer) swap_cnt = 2;
    else if (swap_cnt > 0) begin
      swap_cnt--;
      if (swap_cnt == 0) swap_done = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse_go();
    frame_go = 1'b1;
    tick();
    frame_go = 1'b0;
  endtask

  task automatic pulse_commit();
    frame_commit = 1'b1;
    tick();
    frame_commit = 1'b0;
  endtask

  task automatic push_cmd(input logic [9:0] xs, input logic [9:0] xl, input logic [8:0] ys,
                          input logic [8:0] yl, input logic [31:0] col);
    cmd_x_start = xs; cmd_x_length = xl; cmd_y_start = ys; cmd_y_length = yl; cmd_color = col;
    cmd_valid = 1'b1;
    for (int k = 0; k < 50 && !cmd_ready; k++) tick();
    if (!cmd_ready) check("push_ready_timeout", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    for (int k = 0; k < maxc && frame_busy; k++) tick();
    check(tag, frame_busy, 0);
  endtask

  localparam logic [31:0] OFF1 = 32'h0012_C000;
  localparam logic [31:0] OFF0 = 32'h0000_0000;
  localparam logic [31:0] RED = 32'h00FF_0000, GREEN = 32'h0000_FF00, BLUE = 32'h0000_00FF;

  initial begin
    int base;
    int exp_n;

    // Reset state
    tick(); tick();
    sys_reset = 1'b0;
    check("rst_ready", cmd_ready, 1);
    check("rst_backbuf", back_buf, 1);
    check("rst_busy", frame_busy, 0);
    check("rst_start", if_start, 0);
    check("rst_swap", swap_buffer, 0);
    check("rst_offset", if_base_addr_offset, OFF1);
    check("rst_args", {if_clear, if_x_start, if_x_length, if_y_start, if_y_length, if_new_color}, 0);

    // Frame with no commands
    pulse_go();
    check("t1_start_latency", if_start, 1);
    check("t1_clear_args", {if_clear, if_x_start, if_x_length, if_y_start, if_y_length, if_new_color},
          {1'b1, 10'd0, 10'd1, 9'd0, 9'd1, 32'h0});
    check("t1_offset", if_base_addr_offset, OFF1);
    tick();
    check("t1_single_pulse", if_start, 0);
    pulse_commit();
    wait_idle("t1_idle", 60);
    check("t1_n_start", recs.size(), 1);
    check("t1_n_swap", n_swap, 1);
    check("t1_backbuf", back_buf, 0);
    check("t1_offset_after", if_base_addr_offset, OFF0);

    // Three rects pushed during clear, extra frame_go ignored
    base = recs.size();
    pulse_go();
    hold_done = 1'b1;
    push_cmd(10'd10, 10'd5, 9'd20, 9'd5, RED);
    push_cmd(10'd0, 10'd640, 9'd0, 9'd480, BLUE);
    push_cmd(10'd100, 10'd1, 9'd50, 9'd1, GREEN);
    pulse_go();
    pulse_commit();
    hold_done = 1'b0;
    wait_idle("t2_idle", 100);
    check("t2_n_start", recs.size() - base, 4);
    check("t2_clear", recs[base], mk(1'b1, 0, 1, 0, 1, 32'h0, OFF0));
    check("t2_rect0", recs[base+1], mk(1'b0, 10, 5, 20, 5, RED, OFF0));
    check("t2_rect1", recs[base+2], mk(1'b0, 0, 640, 0, 480, BLUE, OFF0));
    check("t2_rect2", recs[base+3], mk(1'b0, 100, 1, 50, 1, GREEN, OFF0));
    check("t2_backbuf", back_buf, 1);
    check("t2_n_swap", n_swap, 2);

    // Nine commands into an eight-deep FIFO
    base = recs.size();
    pulse_go();
    hold_done = 1'b1;
    for (int i = 0; i < 8; i++)
      push_cmd(10'(i*3+1), 10'(i+1), 9'(i+2), 9'(i+4), 32'hA0 + 32'(i));
    check("t3_full_ready", cmd_ready, 0);
    cmd_x_start = 10'd25; cmd_x_length = 10'd9; cmd_y_start = 9'd10; cmd_y_length = 9'd12;
    cmd_color = 32'hA8;
    cmd_valid = 1'b1;
    hold_done = 1'b0;
    for (int k = 0; k < 20 && !cmd_ready; k++) tick();
    check("t3_ready_rise", cmd_ready, 1);
    check("t3_not_yet_issued", if_start, 0);
    tick();
    cmd_valid = 1'b0;
    check("t3_pop_cycle", if_start, 1);
    pulse_commit();
    wait_idle("t3_idle", 400);
    check("t3_n_start", recs.size() - base, 10);
    for (int i = 0; i < 9; i++)
      check($sformatf("t3_rect%0d", i), recs[base+1+i],
            mk(1'b0, 10'(i*3+1), 10'(i+1), 9'(i+2), 9'(i+4), 32'hA0 + 32'(i), OFF1));
    check("t3_backbuf", back_buf, 0);

    // Reset during DRAW_WAIT with four still queued
    base = recs.size();
    pulse_go();
    hold_done = 1'b1;
    for (int i = 0; i < 5; i++) push_cmd(10'(i+1), 10'd2, 9'(i+1), 9'd2, 32'hC0 + 32'(i));
    hold_done = 1'b0;
    for (int k = 0; k < 40 && recs.size() < base + 2; k++) tick();
    hold_done = 1'b1;
    tick();
    check("t4_first_draw", recs.size() - base, 2);
    sys_reset = 1'b1;
    tick();
    check("t4_rst_busy", frame_busy, 0);
    check("t4_rst_ready", cmd_ready, 1);
    check("t4_rst_backbuf", back_buf, 1);
    sys_reset = 1'b0;
    hold_done = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    check("t4_stale_done", {frame_busy, 32'(recs.size() - base)}, {1'b0, 32'd2});
    pulse_go();
    pulse_commit();
    wait_idle("t4_idle", 60);
    check("t4_fifo_flushed", recs.size() - base, 3);
    check("t4_backbuf", back_buf, 0);

    // Zero-length rect, and commit in IDLE is ignored
    base = recs.size();
    pulse_commit();
    pulse_go();
    push_cmd(10'd5, 10'd0, 9'd5, 9'd3, 32'h11);
    push_cmd(10'd5, 10'd2, 9'd5, 9'd2, 32'h22);
    for (int k = 0; k < 30; k++) tick();
    check("t5_commit_ignored_idle", frame_busy, 1);
    pulse_commit();
    wait_idle("t5_idle", 60);
`ifdef DROP_EMPTY_RECT_EN
    exp_n = 2;
`else
    exp_n = 3;
`endif
    check("t5_n_start", recs.size() - base, exp_n);
    check("t5_last_rect", recs[recs.size()-1], mk(1'b0, 5, 2, 5, 2, 32'h22, OFF0));
    check("args_stable", stab_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
